csr_file: RTL and testbench

Machine-mode CSR register file serving the Execute stage's CSR interface. Execute presents `destinationCSR` and reads `csrReadData` combinationally; legalized write values return from the commit end of the pipeline one or more cycles later. The block also owns:

- trap-entry and `mret` side effects on the machine CSRs;
- the free-running `mcycle` and `minstret` counters;
- interrupt-pending generation for the pipeline.

---
 rtl/csr_file.sv | 172 +++++++++++++++++
 tb/tb_csr_file.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads, commit-side writes, trap/mret side effects,
// mcycle/minstret counters. Interrupt capture is built only with `define CSR_INTERRUPT_EN.
package csr_pkg;
   typedef enum logic [11:0] {
      MSTATUS  = 12'h300,
      MIE      = 12'h304,
      MTVEC    = 12'h305,
      MSCRATCH = 12'h340,
      MEPC     = 12'h341,
      MCAUSE   = 12'h342,
      MTVAL    = 12'h343,
      MIP      = 12'h344,
      MCYCLE   = 12'hB00,
      MINSTRET = 12'hB02
   } destinationCSR_;
endpackage

module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic           clock_i,
   input  logic           reset_i,
   input  destinationCSR_ readAddress_i,
   output logic [31:0]    readData_o,
   input  logic           writeEnable_i,
   input  destinationCSR_ writeAddress_i,
   input  logic [31:0]    writeData_i,
   input  logic           retire_i,
   input  logic           trapValid_i,
   input  logic [31:0]    trapCause_i,
   input  logic [31:0]    trapPC_i,
   input  logic [31:0]    trapValue_i,
   input  logic           mretValid_i,
   input  logic           softwareInterrupt_i,
   input  logic           timerInterrupt_i,
   input  logic           externalInterrupt_i,
   output logic           interruptPending_o,
   output logic [31:0]    interruptCause_o,
   output logic [31:0]    trapVector_o,
   output logic [31:0]    returnAddress_o
);

   logic [31:0] mstatus_q, mepc_q, mtvec_q, mie_q, mscratch_q, mcause_q, mtval_q, mcycle_q, minstret_q;
   logic [31:0] mstatus_d, mepc_d, mtvec_d, mie_d, mscratch_d, mcause_d, mtval_d, mcycle_d, minstret_d;
   logic [31:0] mip;
   logic [31:0] mstatus_rd;
   logic        wr_ok;
   logic        unused_trap_lsb;

   assign unused_trap_lsb = ^trapPC_i[1:0];
   // MPP is hardwired to machine mode; storage keeps whatever was written.
   assign mstatus_rd      = mstatus_q | 32'h0000_1800;
   assign trapVector_o    = {mtvec_q[31:2], 2'b00};
   assign returnAddress_o = mepc_q;

   always_comb begin
      readData_o = '0;
      case (readAddress_i)
         MSTATUS:  readData_o = mstatus_rd;
         MIE:      readData_o = mie_q;
         MTVEC:    readData_o = mtvec_q;
         MSCRATCH: readData_o = mscratch_q;
         MEPC:     readData_o = mepc_q;
         MCAUSE:   readData_o = mcause_q;
         MTVAL:    readData_o = mtval_q;
         MIP:      readData_o = mip;
         MCYCLE:   readData_o = mcycle_q;
         MINSTRET: readData_o = minstret_q;
         default:  readData_o = '0;
      endcase
   end

   always_comb begin
      mstatus_d  = mstatus_q;
      mepc_d     = mepc_q;
      mtvec_d    = mtvec_q;
      mie_d      = mie_q;
      mscratch_d = mscratch_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + 32'd1;
      minstret_d = minstret_q + {31'b0, retire_i};
      wr_ok      = writeEnable_i & ~trapValid_i;
      if (trapValid_i) begin
         mepc_d       = {trapPC_i[31:2], 2'b00};
         mcause_d     = trapCause_i;
         mtval_d      = trapValue_i;
         mstatus_d[7] = mstatus_q[3];
         mstatus_d[3] = 1'b0;
      end else if (mretValid_i) begin
         mstatus_d[3] = mstatus_q[7];
         mstatus_d[7] = 1'b1;
      end
      if (wr_ok) begin
         case (writeAddress_i)
            MSTATUS:  if (!mretValid_i) mstatus_d = writeData_i;
            MIE:      mie_d      = writeData_i;
            MTVEC:    mtvec_d    = writeData_i;
            MSCRATCH: mscratch_d = writeData_i;
            MEPC:     mepc_d     = writeData_i;
            MCAUSE:   mcause_d   = writeData_i;
            MTVAL:    mtval_d    = writeData_i;
            MCYCLE:   mcycle_d   = writeData_i;
            MINSTRET: minstret_d = writeData_i;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         mstatus_q  <= 32'h0000_1800;
         mepc_q     <= '0;
         mtvec_q    <= MTVEC_RESET;
         mie_q      <= '0;
         mscratch_q <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mepc_q     <= mepc_d;
         mtvec_q    <= mtvec_d;
         mie_q      <= mie_d;
         mscratch_q <= mscratch_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

`ifdef CSR_INTERRUPT_EN
   logic [2:0]  irq_s1_q, irq_s2_q;
   logic [31:0] mip_q, irq_en;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         irq_s1_q <= '0;
         irq_s2_q <= '0;
         mip_q    <= '0;
      end else begin
         irq_s1_q <= {externalInterrupt_i, timerInterrupt_i, softwareInterrupt_i};
         irq_s2_q <= irq_s1_q;
         mip_q    <= {20'b0, irq_s2_q[2], 3'b0, irq_s2_q[1], 3'b0, irq_s2_q[0], 3'b0};
      end
   end

   assign mip                = mip_q;
   assign irq_en             = mip_q & mie_q;
   assign interruptPending_o = mstatus_q[3] & (|irq_en);

   always_comb begin
      interruptCause_o = '0;
      if (mstatus_q[3]) begin
         if (irq_en[11])     interruptCause_o = 32'h8000_000B;
         else if (irq_en[3]) interruptCause_o = 32'h8000_0003;
         else if (irq_en[7]) interruptCause_o = 32'h8000_0007;
      end
   end
`else
   logic unused_irq;
   assign unused_irq         = softwareInterrupt_i ^ timerInterrupt_i ^ externalInterrupt_i;
   assign mip                = '0;
   assign interruptPending_o = 1'b0;
   assign interruptCause_o   = '0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected values, a negedge monitor compares.
module tb_csr_file;
   import csr_pkg::*;

   localparam logic [31:0] MTV = 32'h8000_0101;

   logic           clock_i = 1'b0;
   logic           reset_i;
   destinationCSR_ readAddress_i, writeAddress_i, bad_addr;
   logic [31:0]    readData_o, writeData_i, trapCause_i, trapPC_i, trapValue_i;
   logic           writeEnable_i, retire_i, trapValid_i, mretValid_i;
   logic           softwareInterrupt_i, timerInterrupt_i, externalInterrupt_i;
   logic           interruptPending_o;
   logic [31:0]    interruptCause_o, trapVector_o, returnAddress_o;

   csr_file #(.MTVEC_RESET(MTV)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .readAddress_i(readAddress_i), .readData_o(readData_o),
      .writeEnable_i(writeEnable_i), .writeAddress_i(writeAddress_i), .writeData_i(writeData_i),
      .retire_i(retire_i), .trapValid_i(trapValid_i), .trapCause_i(trapCause_i),
      .trapPC_i(trapPC_i), .trapValue_i(trapValue_i), .mretValid_i(mretValid_i),
      .softwareInterrupt_i(softwareInterrupt_i), .timerInterrupt_i(timerInterrupt_i),
      .externalInterrupt_i(externalInterrupt_i),
      .interruptPending_o(interruptPending_o), .interruptCause_o(interruptCause_o),
      .trapVector_o(trapVector_o), .returnAddress_o(returnAddress_o)
   );

   always #5 clock_i = ~clock_i;

   // sel: 0 readData, 1 interruptPending, 2 interruptCause, 3 trapVector, 4 returnAddress
   string       nm_q[$];
   int          sel_q[$];
   logic [31:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] actual(input int s);
      case (s)
         0:       return readData_o;
         1:       return {31'b0, interruptPending_o};
         2:       return interruptCause_o;
         3:       return trapVector_o;
         default: return returnAddress_o;
      endcase
   endfunction

   always @(negedge clock_i) begin
      while (exp_q.size() > 0) begin
         string       n;
         int          s;
         logic [31:0] e, a;
         n = nm_q.pop_front();
         s = sel_q.pop_front();
         e = exp_q.pop_front();
         a = actual(s);
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
         end
      end
   end

   task automatic push(input string n, input int s, input logic [31:0] e);
      nm_q.push_back(n);
      sel_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic rd(input string n, input destinationCSR_ a, input logic [31:0] e);
      readAddress_i = a;
      push(n, 0, e);
   endtask

   task automatic wr(input destinationCSR_ a, input logic [31:0] d);
      writeEnable_i  = 1'b1;
      writeAddress_i = a;
      writeData_i    = d;
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic idle();
      writeEnable_i = 1'b0;
      trapValid_i   = 1'b0;
      mretValid_i   = 1'b0;
      retire_i      = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1;
      readAddress_i = MSTATUS; writeAddress_i = MSTATUS; writeData_i = '0;
      trapCause_i = '0; trapPC_i = '0; trapValue_i = '0;
      softwareInterrupt_i = 1'b0; timerInterrupt_i = 1'b0; externalInterrupt_i = 1'b0;
      idle();
      bad_addr = destinationCSR_'(12'h7C0);
      step();

      // Reset state
      rd("rst_mstatus", MSTATUS, 32'h0000_1800);
      push("rst_pend", 1, 32'd0); push("rst_cause", 2, 32'd0);
      push("rst_tvec", 3, 32'h8000_0100); push("rst_ret", 4, 32'd0);
      step(); rd("rst_mtvec", MTVEC, MTV);
      step(); rd("rst_mie", MIE, 32'd0);
      step(); rd("rst_mscratch", MSCRATCH, 32'd0);
      step(); rd("rst_mepc", MEPC, 32'd0);
      step(); rd("rst_mcause", MCAUSE, 32'd0);
      step(); rd("rst_mtval", MTVAL, 32'd0);
      step(); rd("rst_mip", MIP, 32'd0);
      step(); rd("rst_mcycle", MCYCLE, 32'd0);
      step(); rd("rst_minstret", MINSTRET, 32'd0);
      step(); rd("unknown_addr", bad_addr, 32'd0);
      step();
      reset_i = 1'b0;
      repeat (5) step();
      rd("mcycle_5", MCYCLE, 32'd5);
      step();

      // Write visibility, no bypass
      wr(MSCRATCH, 32'hDEAD_BEEF); rd("scr_old", MSCRATCH, 32'd0);
      step(); idle(); rd("scr_new", MSCRATCH, 32'hDEAD_BEEF);
      step();

      // Trap drops a same-cycle write; mret restores MIE
      wr(MSTATUS, 32'h0000_1888);
      step(); idle(); rd("mstatus_wr", MSTATUS, 32'h0000_1888);
      trapValid_i = 1'b1; trapPC_i = 32'h103; trapCause_i = 32'd2; trapValue_i = 32'h55;
      wr(MEPC, 32'h1234_5678);
      step(); idle(); rd("trap_mcause", MCAUSE, 32'd2); push("trap_ret", 4, 32'h100);
      step(); rd("trap_mstatus", MSTATUS, 32'h0000_1880);
      step(); rd("trap_mtval", MTVAL, 32'h55);
      step(); rd("trap_mepc_dropwr", MEPC, 32'h100);
      mretValid_i = 1'b1; wr(MSTATUS, 32'd0);
      step(); idle(); rd("mret_mstatus", MSTATUS, 32'h0000_1888);
      mretValid_i = 1'b1; wr(MSCRATCH, 32'h11);
      step(); idle(); rd("mret_wr_other", MSCRATCH, 32'h11);
      step(); rd("mret2_mstatus", MSTATUS, 32'h0000_1888);
      trapValid_i = 1'b1; mretValid_i = 1'b1; trapPC_i = 32'h208; trapCause_i = 32'd7;
      step(); idle(); rd("trap_over_mret", MSTATUS, 32'h0000_1880); push("trap2_ret", 4, 32'h208);
      mretValid_i = 1'b1;
      step(); idle(); rd("mret3_mstatus", MSTATUS, 32'h0000_1888);
      wr(MTVEC, 32'h2003);
      step(); idle(); rd("mtvec_rd", MTVEC, 32'h2003); push("tvec_mask", 3, 32'h2000);
      step();

      // minstret wrap, write-cycle retire ignored, trap-cycle retire counted
      wr(MINSTRET, 32'hFFFF_FFFF); retire_i = 1'b1;
      step(); writeEnable_i = 1'b0; rd("minstret_ld", MINSTRET, 32'hFFFF_FFFF);
      step(); rd("minstret_wrap", MINSTRET, 32'd0);
      step(); idle(); rd("minstret_1", MINSTRET, 32'd1);
      trapValid_i = 1'b1; trapPC_i = 32'h300; retire_i = 1'b1; wr(MINSTRET, 32'h50);
      step(); idle(); rd("minstret_trap", MINSTRET, 32'd2);
      step();

      // mcycle load and wrap, mip read-only
      wr(MCYCLE, 32'hFFFF_FFFF);
      step(); idle(); rd("mcycle_ld", MCYCLE, 32'hFFFF_FFFF);
      step(); rd("mcycle_wrap", MCYCLE, 32'd0);
      wr(MIP, 32'hFFF);
      step(); idle(); rd("mip_ro", MIP, 32'd0);
      step();

      // Interrupts: 3-edge latency, external over timer
      wr(MIE, 32'h880);
      step(); wr(MSTATUS, 32'h0000_1808);
      step(); idle(); rd("mie_rd", MIE, 32'h880);
      timerInterrupt_i = 1'b1; externalInterrupt_i = 1'b1;
      push("irq_e0", 1, 32'd0);
      step(); push("irq_e1", 1, 32'd0);
      step(); push("irq_e2", 1, 32'd0);
      step();
`ifdef CSR_INTERRUPT_EN
      push("irq_e3", 1, 32'd1); push("cause_ext", 2, 32'h8000_000B); rd("mip_rd", MIP, 32'h880);
`else
      push("irq_e3", 1, 32'd0); push("cause_off", 2, 32'd0); rd("mip_rd", MIP, 32'd0);
`endif
      externalInterrupt_i = 1'b0;
      step(); step();
`ifdef CSR_INTERRUPT_EN
      push("cause_hold", 2, 32'h8000_000B);
`else
      push("cause_hold", 2, 32'd0);
`endif
      step();
`ifdef CSR_INTERRUPT_EN
      push("cause_tmr", 2, 32'h8000_0007); push("pend_tmr", 1, 32'd1);
`else
      push("cause_tmr", 2, 32'd0); push("pend_tmr", 1, 32'd0);
`endif
      wr(MSTATUS, 32'h0000_1800);
      step(); idle(); push("pend_mie0", 1, 32'd0); push("cause_mie0", 2, 32'd0);
      step();

      // Asynchronous reset mid-cycle, counters restart
      #2 reset_i = 1'b1;
      #1 rd("midrst_mcycle", MCYCLE, 32'd0); push("midrst_pend", 1, 32'd0); push("midrst_ret", 4, 32'd0);
      @(negedge clock_i); #1;
      reset_i = 1'b0;
      step(); step(); rd("post_rst_mcycle", MCYCLE, 32'd2);
      step();

      @(negedge clock_i); #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
